// File: rtl/hsp_fifo_reader.sv
// Drains the ungapped HSP result FIFO of Blastn_Array once subject streaming
// has ended. Zero-length records are dropped; every other record is packed
// into one word {score, length, S addr, Q addr} and sent over a valid/ready
// stream to the host bridge. The block runs entirely in the array_clk domain.
module hsp_fifo_reader #(
  parameter int unsigned LENGTH_COUNTER = 8,
  parameter int unsigned LENGTH_WORD    = 32,  // must equal 4 * LENGTH_COUNTER
  parameter int unsigned LENGTH_HSPCNT  = 16
) (
  input  logic                      array_clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      FIFO_empty,
  output logic                      read_HSP,
  input  logic [LENGTH_COUNTER-1:0] hit_add_inQ_UnGap,
  input  logic [LENGTH_COUNTER-1:0] hit_add_inS_UnGap,
  input  logic [LENGTH_COUNTER-1:0] hit_length_UnGap,
  input  logic [LENGTH_COUNTER-1:0] hit_add_score,
  output logic [LENGTH_WORD-1:0]    out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LENGTH_HSPCNT-1:0]  hsp_count,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StPop,
    StCapture,
    StSend,
    StDone
  } state_e;

  state_e                     state_q, state_d;
  logic [LENGTH_WORD-1:0]     out_data_q;
  logic [LENGTH_HSPCNT-1:0]   hsp_count_q;

  // State register; reset overrides a coincident start.
  always_ff @(posedge array_clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and state-decoded outputs.
  always_comb begin
    state_d   = state_q;
    read_HSP  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    busy      = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StCheck;
      end
      StCheck: begin
        state_d = FIFO_empty ? StDone : StPop;
      end
      StPop: begin
        read_HSP = 1'b1;
        state_d  = StCapture;
      end
      StCapture: begin
        // Hit fields are valid this cycle, one cycle after the pop strobe.
        state_d = (hit_length_UnGap == '0) ? StCheck : StSend;
      end
      StSend: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StCheck;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output word register; loaded only in CAPTURE so it holds through a stall.
  always_ff @(posedge array_clk) begin
    if (reset) begin
      out_data_q <= '0;
    end else if (state_q == StCapture) begin
      out_data_q <= {hit_add_score, hit_length_UnGap, hit_add_inS_UnGap, hit_add_inQ_UnGap};
    end
  end

  // Delivered-record counter: cleared by an accepted start, saturating.
  always_ff @(posedge array_clk) begin
    if (reset) begin
      hsp_count_q <= '0;
    end else if (state_q == StIdle && start) begin
      hsp_count_q <= '0;
    end else if (state_q == StSend && out_ready && hsp_count_q != {LENGTH_HSPCNT{1'b1}}) begin
      hsp_count_q <= hsp_count_q + LENGTH_HSPCNT'(1);
    end
  end

  assign out_data  = out_data_q;
  assign hsp_count = hsp_count_q;

endmodule

// File: tb/tb_hsp_fifo_reader.sv
// Bench for hsp_fifo_reader: a behavioural HSP FIFO feeds the reader, the
// expected output words are queued when records are loaded and popped as the
// reader delivers them.
module tb_hsp_fifo_reader;

  logic        array_clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        FIFO_empty;
  logic        read_HSP;
  logic [7:0]  hit_add_inQ_UnGap = '0;
  logic [7:0]  hit_add_inS_UnGap = '0;
  logic [7:0]  hit_length_UnGap = '0;
  logic [7:0]  hit_add_score = '0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] hsp_count;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  // FIFO model: records written by the stimulus tasks, popped by read_HSP.
  logic [7:0]  mem_q  [64];
  logic [7:0]  mem_s  [64];
  logic [7:0]  mem_l  [64];
  logic [7:0]  mem_sc [64];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          pop_cnt = 0;
  logic [31:0] exp_q[$];

  assign FIFO_empty = (rd_ptr == wr_ptr);

  always #5 array_clk = ~array_clk;

  hsp_fifo_reader dut (
    .array_clk         (array_clk),
    .reset             (reset),
    .start             (start),
    .FIFO_empty        (FIFO_empty),
    .read_HSP          (read_HSP),
    .hit_add_inQ_UnGap (hit_add_inQ_UnGap),
    .hit_add_inS_UnGap (hit_add_inS_UnGap),
    .hit_length_UnGap  (hit_length_UnGap),
    .hit_add_score     (hit_add_score),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .hsp_count         (hsp_count),
    .busy              (busy),
    .done              (done)
  );

  // Pop: fields appear the cycle after the strobe; pops while empty still count.
  always @(posedge array_clk) begin
    if (read_HSP) begin
      hit_add_inQ_UnGap <= mem_q[rd_ptr % 64];
      hit_add_inS_UnGap <= mem_s[rd_ptr % 64];
      hit_length_UnGap  <= mem_l[rd_ptr % 64];
      hit_add_score     <= mem_sc[rd_ptr % 64];
      if (rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  task automatic push_rec(input logic [7:0] q, input logic [7:0] s, input logic [7:0] len,
                          input logic [7:0] sc);
    mem_q[wr_ptr % 64]  = q;
    mem_s[wr_ptr % 64]  = s;
    mem_l[wr_ptr % 64]  = len;
    mem_sc[wr_ptr % 64] = sc;
    wr_ptr = wr_ptr + 1;
    if (len != 8'h00) exp_q.push_back({sc, len, s, q});
  endtask

  task automatic load_three(input logic [7:0] mid_len);
    push_rec(8'h05, 8'h40, 8'h0A, 8'h0B);
    push_rec(8'h12, 8'h7E, mid_len, 8'h10);
    push_rec(8'h30, 8'hA1, 8'h08, 8'h09);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge array_clk);
    n_cmp += 6;
    if (read_HSP !== 1'b0) begin n_bad++; $display("FAIL rst_read: got %b want 0", read_HSP); end
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    if (out_data !== 32'h0) begin n_bad++; $display("FAIL rst_data: got %h want 0", out_data); end
    if (hsp_count !== 16'h0) begin n_bad++; $display("FAIL rst_cnt: got %0d want 0", hsp_count); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
    reset = 1'b0;
  endtask

  task automatic test_empty;
    int base;
    bit saw_read;
    base = pop_cnt;
    saw_read = 1'b0;
    @(negedge array_clk);
    start = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge array_clk);
      start = 1'b0;
      if (read_HSP) saw_read = 1'b1;
      if (i == 1) begin
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL empty_busy: got %b want 1", busy); end
      end
      if (i == 2) begin
        n_cmp++;
        if (done !== 1'b1) begin n_bad++; $display("FAIL empty_done: got %b want 1", done); end
      end
      if (i == 3) begin
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          n_bad++; $display("FAIL empty_idle: busy=%b done=%b want 0 0", busy, done);
        end
      end
    end
    n_cmp += 2;
    if (saw_read || pop_cnt != base) begin
      n_bad++; $display("FAIL empty_pop: pops=%0d want 0", pop_cnt - base);
    end
    if (hsp_count !== 16'h0) begin n_bad++; $display("FAIL empty_cnt: got %0d want 0", hsp_count); end
  endtask

  task automatic test_three_records;
    int base, first_rd, first_v;
    bit fin;
    logic [31:0] w;
    base = pop_cnt; first_rd = -1; first_v = -1; fin = 1'b0;
    load_three(8'h0F);
    out_ready = 1'b1;
    @(negedge array_clk);
    start = 1'b1;
    for (int i = 1; i <= 80 && !fin; i++) begin
      @(negedge array_clk);
      start = 1'b0;
      if (read_HSP && first_rd < 0) first_rd = i;
      if (out_valid && first_v < 0) first_v = i;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL three_word: got %h want none", out_data);
        end else begin
          w = exp_q.pop_front();
          if (out_data !== w) begin n_bad++; $display("FAIL three_word: got %h want %h", out_data, w); end
        end
      end
      if (done) fin = 1'b1;
    end
    n_cmp += 6;
    if (!fin) begin n_bad++; $display("FAIL three_done: got no done want pulse"); end
    if (first_rd != 2) begin n_bad++; $display("FAIL three_rdlat: got %0d want 2", first_rd); end
    if (first_v != 4) begin n_bad++; $display("FAIL three_vlat: got %0d want 4", first_v); end
    if (pop_cnt - base != 3) begin n_bad++; $display("FAIL three_pops: got %0d want 3", pop_cnt - base); end
    if (hsp_count !== 16'd3) begin n_bad++; $display("FAIL three_cnt: got %0d want 3", hsp_count); end
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL three_left: got %0d want 0", exp_q.size()); end
    @(negedge array_clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL three_busy: got %b want 0", busy); end
  endtask

  task automatic test_zero_length;
    int base, words;
    bit fin;
    logic [31:0] w;
    base = pop_cnt; words = 0; fin = 1'b0;
    load_three(8'h00);
    out_ready = 1'b1;
    @(negedge array_clk);
    start = 1'b1;
    for (int i = 1; i <= 80 && !fin; i++) begin
      @(negedge array_clk);
      start = 1'b0;
      if (out_valid && out_ready) begin
        n_cmp++; words++;
        w = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        if (out_data !== w) begin n_bad++; $display("FAIL zero_word: got %h want %h", out_data, w); end
      end
      if (done) fin = 1'b1;
    end
    n_cmp += 4;
    if (!fin) begin n_bad++; $display("FAIL zero_done: got no done want pulse"); end
    if (words != 2) begin n_bad++; $display("FAIL zero_words: got %0d want 2", words); end
    if (pop_cnt - base != 3) begin n_bad++; $display("FAIL zero_pops: got %0d want 3", pop_cnt - base); end
    if (hsp_count !== 16'd2) begin n_bad++; $display("FAIL zero_cnt: got %0d want 2", hsp_count); end
  endtask

  task automatic test_stall;
    int base, guard;
    bit fin;
    logic [31:0] held, w;
    base = pop_cnt; fin = 1'b0;
    load_three(8'h0F);
    out_ready = 1'b0;
    @(negedge array_clk);
    start = 1'b1;
    guard = 0;
    do begin
      @(negedge array_clk);
      start = 1'b0;
      guard++;
    end while (!out_valid && guard < 20);
    n_cmp++;
    if (!out_valid) begin n_bad++; $display("FAIL stall_valid: got 0 want 1 within 20 cycles"); end
    held = out_data;
    for (int j = 1; j <= 10; j++) begin
      if (j > 1) @(negedge array_clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== held || read_HSP !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold: valid=%b data=%h read=%b want 1 %h 0", out_valid, out_data,
                 read_HSP, held);
      end
    end
    n_cmp += 2;
    if (pop_cnt - base != 1) begin n_bad++; $display("FAIL stall_pops: got %0d want 1", pop_cnt - base); end
    w = exp_q.pop_front();
    if (held !== w) begin n_bad++; $display("FAIL stall_word: got %h want %h", held, w); end
    out_ready = 1'b1;
    @(negedge array_clk);
    n_cmp += 2;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_accept: valid=%b want 0", out_valid); end
    if (hsp_count !== 16'd1) begin n_bad++; $display("FAIL stall_cnt1: got %0d want 1", hsp_count); end
    for (int i = 1; i <= 80 && !fin; i++) begin
      @(negedge array_clk);
      if (out_valid && out_ready) begin
        n_cmp++;
        w = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        if (out_data !== w) begin n_bad++; $display("FAIL stall_word: got %h want %h", out_data, w); end
      end
      if (done) fin = 1'b1;
    end
    n_cmp += 2;
    if (!fin) begin n_bad++; $display("FAIL stall_done: got no done want pulse"); end
    if (hsp_count !== 16'd3) begin n_bad++; $display("FAIL stall_cnt: got %0d want 3", hsp_count); end
  endtask

  task automatic test_restart;
    int base, words, dones;
    logic [31:0] w;
    base = pop_cnt; words = 0; dones = 0;
    load_three(8'h0F);
    out_ready = 1'b1;
    @(negedge array_clk);
    start = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge array_clk);
      if (out_valid && out_ready) begin
        n_cmp++; words++;
        w = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        if (out_data !== w) begin n_bad++; $display("FAIL restart_word: got %h want %h", out_data, w); end
      end
      if (done) dones++;
      start = (i == 3 || i == 6 || i == 9);
    end
    start = 1'b0;
    n_cmp += 4;
    if (words != 3) begin n_bad++; $display("FAIL restart_words: got %0d want 3", words); end
    if (dones != 1) begin n_bad++; $display("FAIL restart_done: got %0d want 1", dones); end
    if (pop_cnt - base != 3) begin n_bad++; $display("FAIL restart_pops: got %0d want 3", pop_cnt - base); end
    if (hsp_count !== 16'd3) begin n_bad++; $display("FAIL restart_cnt: got %0d want 3", hsp_count); end
  endtask

  task automatic test_reset_mid;
    int base, guard;
    logic [31:0] w;
    base = pop_cnt;
    push_rec(8'h21, 8'h33, 8'h04, 8'h55);
    push_rec(8'h44, 8'h66, 8'h02, 8'h77);
    out_ready = 1'b0;
    @(negedge array_clk);
    start = 1'b1;
    guard = 0;
    do begin
      @(negedge array_clk);
      start = 1'b0;
      guard++;
    end while (!out_valid && guard < 20);
    n_cmp++;
    if (!out_valid) begin n_bad++; $display("FAIL rmid_valid: got 0 want 1 within 20 cycles"); end
    reset = 1'b1;
    @(negedge array_clk);
    reset = 1'b0;
    w = exp_q.pop_front();  // popped but never delivered
    n_cmp += 5;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid0: got %b want 0", out_valid); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    if (hsp_count !== 16'h0) begin n_bad++; $display("FAIL rmid_cnt: got %0d want 0", hsp_count); end
    if (read_HSP !== 1'b0) begin n_bad++; $display("FAIL rmid_read: got %b want 0", read_HSP); end
    if (out_data !== 32'h0) begin n_bad++; $display("FAIL rmid_data: got %h want 0", out_data); end
    repeat (5) @(negedge array_clk);
    n_cmp++;
    if (pop_cnt - base != 1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rmid_nopop: pops=%0d busy=%b want 1 0", pop_cnt - base, busy);
    end
    start = 1'b1;
    reset = 1'b1;
    @(negedge array_clk);
    start = 1'b0;
    reset = 1'b0;
    @(negedge array_clk);
    n_cmp++;
    if (busy !== 1'b0 || pop_cnt - base != 1) begin
      n_bad++; $display("FAIL rmid_startrst: busy=%b pops=%0d want 0 1", busy, pop_cnt - base);
    end
    if (w == 32'h0) n_cmp = n_cmp;  // keep the dropped word referenced
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_empty();
    test_three_records();
    test_zero_length();
    test_stall();
    test_restart();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
